// File: rtl/apb_pkg.sv
// Shared APB definitions used by the command master and the memory-mapped slave.
package apb_pkg;

    // Transfer phase of an APB requester/completer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB bus, bundled for the command master.
interface apb_cmd_master_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    // Command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    // Requester view (the command master itself).
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Environment view: command source, response sink and APB completer.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the cycle on which the wait limit is hit.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Expiry fires on the TIMEOUT-th wait cycle, i.e. while the count still reads TIMEOUT-1.
    localparam logic [CntW-1:0] Limit = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise saturating increment while waiting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && enable_i && (count_q == Limit);

endmodule

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers with a wait timeout.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_cmd_master_if.master  bus
);

    apb_state_e state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic cmd_ready;
    logic accept;
    logic expired;
    logic timer_clear;
    logic timer_en;

    // Ready in IDLE, or on the completing ACCESS cycle so commands can chain without a gap.
    assign cmd_ready   = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);
    assign accept      = bus.cmd_valid && cmd_ready;
    assign timer_en    = (state_q == ACCESS) && !bus.PREADY;
    assign timer_clear = (state_d == SETUP);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (expired)
    );

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d = accept ? SETUP : IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: bus phase follows the next state, fields latch on accept.
    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
        end

        if (state_q == ACCESS) begin
            if (bus.PREADY) begin
                rsp_valid_d = 1'b1;
                if (!pwrite_q) rsp_rdata_d = bus.PRDATA;
            end else if (expired) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: command driver, timed APB completer model and response scoreboard.
module tb_apb_cmd_master;

    localparam int unsigned TO = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_cmd_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus.master)
    );

    typedef struct {
        int unsigned acc;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    xfer_t       xq[$];
    rsp_t        sb[$];
    xfer_t       cur;
    bit          active = 1'b0;
    int unsigned k = 0;
    int unsigned cyc = 0;
    logic [31:0] last_rd = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Completer model and bus/response monitor; cycle numbers are posedges seen so far.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            bus.PREADY = 1'b0;
            active     = 1'b0;
        end else begin
            if (xq.size() != 0 && xq[0].acc == cyc) begin
                chk("setup_phase", {bus.PSEL, bus.PENABLE}, 2'b10);
                chk("setup_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA},
                    {xq[0].w, xq[0].addr, xq[0].wdata});
                cur    = xq.pop_front();
                active = 1'b1;
                k      = 0;
                // Driven high on purpose: must be ignored during SETUP.
                bus.PREADY = 1'b1;
                bus.PRDATA = $urandom;
            end else if (active) begin
                chk("access_phase", {bus.PSEL, bus.PENABLE}, 2'b11);
                chk("access_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA},
                    {cur.w, cur.addr, cur.wdata});
                bus.PREADY = (k >= cur.waits);
                bus.PRDATA = bus.PREADY ? cur.rdata : $urandom;
                if (bus.PREADY || k == TO - 1) active = 1'b0;
                k++;
            end else begin
                chk("idle_phase", {bus.PSEL, bus.PENABLE}, 2'b00);
                bus.PREADY = 1'b0;
                bus.PRDATA = $urandom;
            end

            if (sb.size() != 0 && sb[0].due == cyc) begin
                chk("rsp_valid", bus.rsp_valid, 1'b1);
                chk("rsp_err", bus.rsp_err, sb[0].err);
                chk("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
                void'(sb.pop_front());
            end else if (bus.rsp_valid) begin
                chk("rsp_spurious", bus.rsp_valid, 1'b0);
            end
        end
    end

    // Offer one command; called and returns just after a falling edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int unsigned waits, input logic [31:0] rd);
        xfer_t x;
        rsp_t  r;
        int    n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", bus.cmd_ready, 1'b1);
            bus.cmd_valid = 1'b0;
            return;
        end
        x.acc   = cyc + 1;
        x.w     = w;
        x.addr  = a;
        x.wdata = d;
        x.waits = waits;
        x.rdata = rd;
        xq.push_back(x);
        if (waits >= TO) begin
            r.due   = x.acc + 1 + TO;
            r.err   = 1'b1;
            r.rdata = '0;
        end else begin
            r.due   = x.acc + 2 + waits;
            r.err   = 1'b0;
            r.rdata = w ? last_rd : rd;
        end
        last_rd = r.rdata;
        sb.push_back(r);
        @(posedge PCLK);
        @(negedge PCLK);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || xq.size() != 0 || active) && n < 60) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        chk("drain", {sb.size() == 0, xq.size() == 0, active}, 3'b110);
        repeat (2) begin
            @(negedge PCLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;

        repeat (2) @(negedge PCLK);
        #1;
        chk("reset_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err}, 5'b0);
        chk("reset_paddr", bus.PADDR, 32'h0);
        chk("reset_pwdata", bus.PWDATA, 32'h0);
        chk("reset_rdata", bus.rsp_rdata, 32'h0);
        chk("reset_ready", bus.cmd_ready, 1'b1);
        PRESETn = 1'b1;
        @(negedge PCLK);
        #1;

        // Zero-wait write.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        wait_drain();

        // Read with two wait states.
        issue(1'b0, 32'h20, 32'h0, 2, 32'hA5A50001);
        wait_drain();

        // Back-to-back write then read on the same address.
        issue(1'b1, 32'h4, 32'h12345678, 0, 32'h0);
        issue(1'b0, 32'h4, 32'h0, 1, 32'h0BADF00D);
        wait_drain();

        // Stuck completer aborts, then the next command runs normally.
        issue(1'b1, 32'h30, 32'h77, 100, 32'h0);
        wait_drain();
        issue(1'b0, 32'h34, 32'hCAFE0034, 0, 32'h5555AAAA);
        wait_drain();

        // Idle stability.
        repeat (20) begin
            @(negedge PCLK);
            #1;
            chk("idle_ready", bus.cmd_ready, 1'b1);
            chk("idle_hold", {bus.PADDR, bus.PWDATA}, {32'h34, 32'hCAFE0034});
        end

        // Reset in the middle of an ACCESS wait state.
        issue(1'b0, 32'h40, 32'h0, 3, 32'h1);
        @(negedge PCLK);
        #3;
        PRESETn = 1'b0;
        #1;
        chk("arst_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err}, 5'b0);
        chk("arst_data", {bus.PADDR, bus.PWDATA, bus.rsp_rdata}, 96'h0);
        xq.delete();
        sb.delete();
        active  = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge PCLK);
        #1;
        chk("arst_no_rsp", bus.rsp_valid, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        #1;
        chk("post_rst_idle", {bus.cmd_ready, bus.PSEL, bus.PENABLE}, 3'b100);

        // Normal transfer after reset.
        issue(1'b1, 32'h50, 32'h0F0F0F0F, 1, 32'h0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
